ipod_playback_ctrl: RTL and testbench

- Sequences flash-to-audio playback for the simple iPod.
- Fetches 32-bit words from flash over an Avalon-MM read master and splits each word into two 16-bit samples.
- Emits one sample per synchronized 22 kHz tick and steps the word address forward or backward with wrap-around.
- Sits between the keyboard/command decode, the flash controller and the audio codec path; it replaces ad-hoc address stepping and read sequencing.

---
 rtl/ipod_ctrl_pkg.sv | 25 ++
 rtl/ipod_addr_step.sv | 23 ++
 rtl/ipod_playback_ctrl.sv | 113 +++++++++++
 tb/tb_ipod_playback_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipod_ctrl_pkg.sv
// Shared types and constants for the iPod flash-to-audio playback controller.
// Holds the FSM state encoding, the default song geometry and the half-word selector.
package ipod_ctrl_pkg;

  localparam int ADDR_W = 23;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    WAIT_TICK_A,
    OUT_A,
    WAIT_TICK_B,
    OUT_B,
    ADVANCE
  } state_e;

  typedef enum logic {HALF_LO, HALF_HI} half_e;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input half_e half);
    return (half == HALF_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/ipod_addr_step.sv
// Next flash word address: restart jumps to the start of the song for the current
// direction, otherwise step one word forward/backward with wrap at 0 and LAST_ADDR.
module ipod_addr_step #(
  parameter int                ADDR_W    = ipod_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ipod_ctrl_pkg::LAST_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              dir_fwd,
  input  logic              restart,
  output logic [ADDR_W-1:0] next_addr
);

  always_comb begin
    if (restart) begin
      next_addr = dir_fwd ? '0 : LAST_ADDR;
    end else if (dir_fwd) begin
      next_addr = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    end else begin
      next_addr = (addr == '0) ? LAST_ADDR : addr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ipod_playback_ctrl.sv
// Flash-to-audio playback sequencer: fetches 32-bit words over Avalon-MM, emits two
// 16-bit samples per word on 22 kHz ticks. Optional IPOD_VOLUME_SHIFT_EN adds volume_shift.
module ipod_playback_ctrl #(
  parameter int                ADDR_W     = ipod_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR  = ipod_ctrl_pkg::LAST_ADDR,
  parameter int                UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  play,
  input  logic                  dir_fwd,
  input  logic                  restart,
  output logic                  flash_read,
  output logic [ADDR_W-1:0]     flash_address,
  input  logic                  flash_waitrequest,
  input  logic [31:0]           flash_readdata,
  input  logic                  flash_readdatavalid,
`ifdef IPOD_VOLUME_SHIFT_EN
  input  logic [1:0]            volume_shift,
`endif
  output logic [15:0]           audio_out,
  output logic                  audio_valid,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);
  import ipod_ctrl_pkg::*;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_next_addr;
  logic [31:0]       r_word;
  logic              r_fwd;       // half order of the word in flight
  logic              r_pending;
  logic              r_restart;
  logic              w_consume;
  half_e             w_half;
  logic [15:0]       w_sample, w_shaped;

  ipod_addr_step #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_step (
    .addr      (r_addr),
    .dir_fwd   (dir_fwd),
    .restart   (r_restart | restart),
    .next_addr (w_next_addr)
  );

  assign w_consume = play && (sample_tick || r_pending) &&
                     (r_state == WAIT_TICK_A || r_state == WAIT_TICK_B);

  // Forward plays low half first; backward plays high half first.
  assign w_half   = ((r_state == WAIT_TICK_A) == r_fwd) ? HALF_LO : HALF_HI;
  assign w_sample = pick_half(r_word, w_half);
`ifdef IPOD_VOLUME_SHIFT_EN
  assign w_shaped = $signed(w_sample) >>> volume_shift;
`else
  assign w_shaped = w_sample;
`endif

  assign flash_read    = (r_state == REQ);
  assign flash_address = r_addr;
  assign audio_valid   = (r_state == OUT_A) || (r_state == OUT_B);

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        if (play)                w_state_nxt = REQ;
      REQ:         if (!flash_waitrequest)  w_state_nxt = WAIT_DATA;
      WAIT_DATA:   if (flash_readdatavalid) w_state_nxt = WAIT_TICK_A;
      WAIT_TICK_A: if (w_consume)           w_state_nxt = OUT_A;
      OUT_A:                                w_state_nxt = WAIT_TICK_B;
      WAIT_TICK_B: if (w_consume)           w_state_nxt = OUT_B;
      OUT_B:                                w_state_nxt = ADVANCE;
      ADVANCE:     w_state_nxt = play ? REQ : IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_word       <= '0;
      r_fwd        <= 1'b1;
      r_pending    <= 1'b0;
      r_restart    <= 1'b0;
      audio_out    <= '0;
      underrun_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == IDLE && restart) || r_state == ADVANCE) r_addr <= w_next_addr;
      if ((r_state == IDLE && play) || r_state == ADVANCE)    r_fwd  <= dir_fwd;

      if (r_state == ADVANCE)                  r_restart <= 1'b0;
      else if (restart && r_state != IDLE)     r_restart <= 1'b1;

      if (r_state == WAIT_DATA && flash_readdatavalid) r_word <= flash_readdata;
      if (w_consume) audio_out <= w_shaped;

      // A tick landing while pending is consumed becomes the new pending tick.
      if (w_consume) begin
        r_pending <= r_pending && sample_tick;
      end else if (sample_tick) begin
        r_pending <= 1'b1;
        if (r_pending && underrun_cnt != '1) underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ipod_playback_ctrl.sv
// Self-checking bench for ipod_playback_ctrl: directed vector table, multi-cycle corner
// sequences and randomized playback checked against a word/address-walk reference model.
module tb_ipod_playback_ctrl;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset, sample_tick, play, dir_fwd, restart;
  logic        flash_read, flash_waitrequest, flash_readdatavalid, audio_valid;
  logic [22:0] flash_address;
  logic [31:0] flash_readdata;
  logic [15:0] audio_out, underrun_cnt;
`ifdef IPOD_VOLUME_SHIFT_EN
  logic [1:0]  volume_shift = 2'd0;
`endif

  always #10 clk = ~clk;

  ipod_playback_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .sample_tick         (sample_tick),
    .play                (play),
    .dir_fwd             (dir_fwd),
    .restart             (restart),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
`ifdef IPOD_VOLUME_SHIFT_EN
    .volume_shift        (volume_shift),
`endif
    .audio_out           (audio_out),
    .audio_valid         (audio_valid),
    .underrun_cnt        (underrun_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Flash model / stimulus control
  bit          force_wait, rand_wait, rand_lat, inject_rdv, auto_tick, mon_en;
  int          wr_run, fixed_lat, resp_cnt, tick_cnt, n_ticks, n_valid;
  logic [22:0] resp_addr;
  logic [22:0] acc_q[$];
  // Reference model
  logic [22:0] exp_addr;
  bit          exp_fwd;
  logic [15:0] exp_q[$];

  typedef struct packed {
    logic              to_last;
    logic              fwd;
    logic [0:3][15:0]  smp;
    logic [0:2][22:0]  adr;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flash_word(input logic [22:0] a);
    if (a == 23'd0) return 32'hBBBBAAAA;
    if (a == 23'd1) return 32'hDDDDCCCC;
    if (a == LAST)  return 32'h12345678;
    return {a[15:0] ^ 16'hF0F0, a[15:0] + 16'h1111};
  endfunction

  // The song is a ring of LAST+1 words.
  function automatic logic [22:0] model_next(input logic [22:0] a, input bit fwd);
    int unsigned span = int'(LAST) + 1;
    int unsigned n    = fwd ? (int'(a) + 1) % span : (int'(a) + span - 1) % span;
    return n[22:0];
  endfunction

  // One clock: observe outputs at negedge, then drive inputs for the next posedge.
  task automatic cycle();
    logic [31:0] w;
    bit          wr;
    @(negedge clk);
    if (audio_valid) begin
      n_valid++;
      if (mon_en) begin
        if (exp_q.size() == 0) check("sample_extra", {16'h0, audio_out}, 32'h0001_0000);
        else                   check("sample", {16'h0, audio_out}, {16'h0, exp_q.pop_front()});
      end
    end
    sample_tick = 1'b0;
    restart     = 1'b0;
    flash_readdatavalid = 1'b0;
    if (reset) resp_cnt = -1;
    else if (resp_cnt > 0) resp_cnt--;
    else if (resp_cnt == 0) begin
      flash_readdatavalid = 1'b1;
      flash_readdata      = flash_word(resp_addr);
      resp_cnt            = -1;
    end
    if (inject_rdv) begin
      flash_readdatavalid = 1'b1;
      flash_readdata      = 32'hDEADBEEF;
      inject_rdv          = 1'b0;
    end
    wr = force_wait || (rand_wait && wr_run < 3 && $urandom_range(0, 3) == 0);
    wr_run = wr ? wr_run + 1 : 0;
    flash_waitrequest = wr;
    if (flash_read && !wr && !reset && resp_cnt < 0) begin
      resp_addr = flash_address;
      resp_cnt  = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
      if (mon_en) begin
        check("req_addr", {9'h0, flash_address}, {9'h0, exp_addr});
        w = flash_word(exp_addr);
        if (exp_fwd) begin exp_q.push_back(w[15:0]);  exp_q.push_back(w[31:16]); end
        else         begin exp_q.push_back(w[31:16]); exp_q.push_back(w[15:0]);  end
        exp_addr = model_next(exp_addr, exp_fwd);
      end else begin
        acc_q.push_back(flash_address);
      end
    end
    if (auto_tick) begin
      if (tick_cnt == 0) begin
        sample_tick = 1'b1;
        n_ticks++;
        tick_cnt = int'($urandom_range(16, 40));
      end else tick_cnt--;
    end
  endtask

  task automatic wait_accept(input string name, input logic [22:0] want);
    int k = 0;
    while (acc_q.size() == 0 && k < 60) begin cycle(); k++; end
    if (acc_q.size() == 0) check({name, "_timeout"}, 32'(k), 32'd0);
    else                   check(name, {9'h0, acc_q.pop_front()}, {9'h0, want});
  endtask

  task automatic do_reset(input bit check_vals);
    reset = 1'b1; play = 1'b0; dir_fwd = 1'b1; restart = 1'b0; sample_tick = 1'b0;
    flash_waitrequest = 1'b0; flash_readdatavalid = 1'b0; flash_readdata = '0;
    force_wait = 0; rand_wait = 0; rand_lat = 0; inject_rdv = 0; auto_tick = 0; mon_en = 0;
    wr_run = 0; fixed_lat = 0; resp_cnt = -1;
    acc_q.delete(); exp_q.delete();
    repeat (2) cycle();
    if (check_vals) begin
      check("rst_flash_read",    {31'h0, flash_read},   32'h0);
      check("rst_flash_address", {9'h0, flash_address}, 32'h0);
      check("rst_audio_out",     {16'h0, audio_out},    32'h0);
      check("rst_audio_valid",   {31'h0, audio_valid},  32'h0);
      check("rst_underrun",      {16'h0, underrun_cnt}, 32'h0);
    end
    reset = 1'b0;
    cycle();
  endtask

  // Apply one tick and expect exactly a one-cycle audio_valid pulse carrying smp.
  task automatic tick_expect(input string name, input logic [15:0] smp);
    sample_tick = 1'b1;
    cycle();
    check({name, "_valid"}, {31'h0, audio_valid}, 32'h1);
    check({name, "_out"},   {16'h0, audio_out},   {16'h0, smp});
    cycle();
    check({name, "_pulse"}, {31'h0, audio_valid}, 32'h0);
  endtask

  initial begin
    bit seen_read, seen_valid;

    vecs[0] = '{1'b0, 1'b1, {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}, {23'h0, 23'h1, 23'h2}};
    vecs[1] = '{1'b0, 1'b0, {16'hBBBB, 16'hAAAA, 16'h1234, 16'h5678}, {23'h0, LAST, 23'h7FFFE}};
    vecs[2] = '{1'b1, 1'b1, {16'h5678, 16'h1234, 16'hAAAA, 16'hBBBB}, {LAST, 23'h0, 23'h1}};
    vecs[3] = '{1'b1, 1'b0, {16'h1234, 16'h5678, 16'h0F0E, 16'h110F}, {LAST, 23'h7FFFE, 23'h7FFFD}};

    do_reset(1'b1);

    // Directed table: two words per row, forward/backward, with and without wrap.
    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      fixed_lat = i % 3;
      if (vecs[i].to_last) begin
        dir_fwd = 1'b0; restart = 1'b1;
        cycle();
        check($sformatf("v%0d_restart_idle", i), {9'h0, flash_address}, {9'h0, LAST});
      end
      dir_fwd = vecs[i].fwd;
      play    = 1'b1;
      for (int w = 0; w < 2; w++) begin
        wait_accept($sformatf("v%0d_addr%0d", i, w), vecs[i].adr[w]);
        repeat (6) cycle();
        tick_expect($sformatf("v%0d_s%0d", i, 2 * w),     vecs[i].smp[2 * w]);
        tick_expect($sformatf("v%0d_s%0d", i, 2 * w + 1), vecs[i].smp[2 * w + 1]);
      end
      wait_accept($sformatf("v%0d_addr2", i), vecs[i].adr[2]);
    end

    // Underrun: three ticks while the request is stalled.
    do_reset(1'b0);
    play = 1'b1; force_wait = 1'b1;
    repeat (2) cycle();
    check("ur_req_held", {31'h0, flash_read}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      sample_tick = 1'b1;
      repeat (9) cycle();
    end
    check("ur_count", {16'h0, underrun_cnt}, 32'd2);
    force_wait = 1'b0;
    wait_accept("ur_addr", 23'h0);
    cycle();
    cycle();
    check("ur_no_early", {31'h0, audio_valid}, 32'h0);
    cycle();
    check("ur_first_valid", {31'h0, audio_valid}, 32'h1);
    check("ur_first_out",   {16'h0, audio_out},   32'hAAAA);
    check("ur_count_hold",  {16'h0, underrun_cnt}, 32'd2);

    // Pause mid-word: output frozen, tick goes pending, no flash traffic.
    play = 1'b0;
    sample_tick = 1'b1;
    seen_read = 0; seen_valid = 0;
    repeat (6) begin
      cycle();
      seen_read  |= flash_read;
      seen_valid |= audio_valid;
    end
    check("pause_no_read",  {31'h0, seen_read},  32'h0);
    check("pause_no_valid", {31'h0, seen_valid}, 32'h0);
    check("pause_hold_out", {16'h0, audio_out},  32'hAAAA);
    play = 1'b1;
    cycle();
    check("resume_valid", {31'h0, audio_valid}, 32'h1);
    check("resume_out",   {16'h0, audio_out},   32'hBBBB);

    // Restart during WAIT_DATA: current word completes, then jump to address 0.
    wait_accept("rs_addr1", 23'h1);
    cycle();
    restart = 1'b1;
    cycle();
    repeat (2) cycle();
    tick_expect("rs_a", 16'hCCCC);
    tick_expect("rs_b", 16'hDDDD);
    wait_accept("rs_next_addr", 23'h0);

    // Asynchronous reset during REQ, then a stale readdatavalid while requesting.
    do_reset(1'b0);
    play = 1'b1; force_wait = 1'b1;
    repeat (2) cycle();
    check("ar_req", {31'h0, flash_read}, 32'h1);
    #3 reset = 1'b1;
    #1 check("ar_read_drop", {31'h0, flash_read}, 32'h0);
    play = 1'b0; force_wait = 1'b0;
    cycle();
    reset = 1'b0;
    play = 1'b1; force_wait = 1'b1;
    cycle();
    inject_rdv = 1'b1;
    repeat (3) cycle();
    check("ar_stale_ignored", {31'h0, flash_read}, 32'h1);
    force_wait = 1'b0;
    wait_accept("ar_addr", 23'h0);
    repeat (6) cycle();
    tick_expect("ar_first", 16'hAAAA);

    // Randomized playback against the word-walk model, forward then backward.
    for (int r = 0; r < 2; r++) begin
      do_reset(1'b0);
      dir_fwd  = (r == 0);
      exp_fwd  = (r == 0);
      exp_addr = 23'h0;
      rand_lat = 1; rand_wait = 1; mon_en = 1;
      n_ticks = 0; n_valid = 0;
      tick_cnt  = int'($urandom_range(16, 40));
      auto_tick = 1;
      play      = 1'b1;
      repeat (2500) cycle();
      auto_tick = 0;
      repeat (80) cycle();
      check($sformatf("rand%0d_underrun", r), {16'h0, underrun_cnt}, 32'h0);
      check($sformatf("rand%0d_samples", r), 32'(n_valid), 32'(n_ticks));
      mon_en = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
